sprite_layer_scheduler: RTL and testbench

- Per-pixel sequencer for the single-port sprite ROM (18-bit address, 5-bit palette index, 1-cycle registered read).
- Replaces fixed first-match address selection with transparency-aware layer walking. Layers are read in priority order until a non-transparent index is found or the read budget runs out.
- Sits between the sprite/terrain/background draw logic and the palette-to-RGB lookup. It is the sole driver of the ROM address.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/layer_prio_enc.sv | 22 ++
 rtl/sprite_layer_scheduler.sv | 143 ++++++++++++++
 tb/tb_sprite_layer_scheduler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared widths, ROM address constants, layer order and FSM encoding
package sprite_pkg;

    localparam int PALETTE_W = 5;
    localparam int ADDR_W    = 18;

    localparam logic [ADDR_W-1:0] DEFAULT_ADDR = 18'd1704;
    localparam logic [ADDR_W-1:0] TERRAIN_ADDR = 18'd1705;
    localparam logic [ADDR_W-1:0] BLANK_ADDR   = 18'd1706;

    // Bit position in the pending mask; lower index wins.
    typedef enum logic [2:0] {
        LYR_B1      = 3'd0,
        LYR_P1      = 3'd1,
        LYR_B2      = 3'd2,
        LYR_P2      = 3'd3,
        LYR_TERRAIN = 3'd4,
        LYR_BG      = 3'd5
    } layer_e;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/layer_prio_enc.sv
// rtl/layer_prio_enc.sv - lowest-set-bit encoder selecting the highest-priority pending layer
module layer_prio_enc
    import sprite_pkg::*;
(
    input  logic [5:0] req,
    output logic [2:0] idx,
    output logic       valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_layer_scheduler.sv
// rtl/sprite_layer_scheduler.sv - per-pixel sprite ROM sequencer walking layers until an opaque index
module sprite_layer_scheduler
    import sprite_pkg::*;
#(
    parameter int                   MAX_READS    = 3,
    parameter logic [PALETTE_W-1:0] TRANSP_IDX   = 5'd31,
    parameter logic [PALETTE_W-1:0] FALLBACK_IDX = 5'd0,
    parameter logic [PALETTE_W-1:0] BLANK_IDX    = 5'd18
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 pix_start,
    input  logic                 blank,
    input  logic                 B1D,
    input  logic                 P1D,
    input  logic                 B2D,
    input  logic                 P2D,
    input  logic                 terrain_on,
    input  logic                 drawBG,
    input  logic [ADDR_W-1:0]    B1A,
    input  logic [ADDR_W-1:0]    P1A,
    input  logic [ADDR_W-1:0]    B2A,
    input  logic [ADDR_W-1:0]    P2A,
    input  logic [ADDR_W-1:0]    addrBG,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [PALETTE_W-1:0] rom_q,
    output logic [PALETTE_W-1:0] palette_out,
    output logic                 palette_valid,
    output logic                 overflow,
    output logic                 miss,
    output logic                 busy
);

    localparam logic [2:0] MAX_R = 3'(MAX_READS);

    state_t            state;
    logic [5:0]        pending;
    logic [2:0]        reads;
    logic [ADDR_W-1:0] b1a_q, p1a_q, b2a_q, p2a_q, bg_q;
    logic [ADDR_W-1:0] last_addr;
    logic              ovf_q;
    logic              miss_q;
    logic [2:0]        enc_idx;
    logic              enc_valid;
    logic [5:0]        flags;

    assign flags = {drawBG, terrain_on, P2D, B2D, P1D, B1D};

    layer_prio_enc u_enc (
        .req   (pending),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        rom_addr = DEFAULT_ADDR;
        if (state == ST_ISSUE && enc_valid) begin
            case (layer_e'(enc_idx))
                LYR_B1:      rom_addr = b1a_q;
                LYR_P1:      rom_addr = p1a_q;
                LYR_B2:      rom_addr = b2a_q;
                LYR_P2:      rom_addr = p2a_q;
                LYR_TERRAIN: rom_addr = TERRAIN_ADDR;
                LYR_BG:      rom_addr = bg_q;
                default:     rom_addr = DEFAULT_ADDR;
            endcase
        end else if (state == ST_CHECK) begin
            rom_addr = last_addr;
        end
    end

    assign busy          = (state != ST_IDLE);
    assign palette_valid = (state == ST_DONE);
    assign overflow      = (state == ST_DONE) && ovf_q;
    assign miss          = miss_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            pending     <= 6'd0;
            reads       <= 3'd0;
            palette_out <= BLANK_IDX;
            ovf_q       <= 1'b0;
            miss_q      <= 1'b0;
            last_addr   <= DEFAULT_ADDR;
            b1a_q       <= '0;
            p1a_q       <= '0;
            b2a_q       <= '0;
            p2a_q       <= '0;
            bg_q        <= '0;
        end else begin
            miss_q <= 1'b0;
            if (pix_start) begin
                // A start in DONE is not a miss: that pixel's result is already out.
                miss_q  <= (state == ST_ISSUE) || (state == ST_CHECK);
                pending <= flags;
                reads   <= 3'd0;
                ovf_q   <= 1'b0;
                b1a_q   <= B1A;
                p1a_q   <= P1A;
                b2a_q   <= B2A;
                p2a_q   <= P2A;
                bg_q    <= addrBG;
                if (!blank) begin
                    palette_out <= BLANK_IDX;
                    state       <= ST_DONE;
                end else if (flags == 6'd0) begin
                    palette_out <= FALLBACK_IDX;
                    state       <= ST_DONE;
                end else begin
                    state <= ST_ISSUE;
                end
            end else begin
                case (state)
                    ST_ISSUE: begin
                        pending   <= pending & (pending - 6'd1);
                        reads     <= reads + 3'd1;
                        last_addr <= rom_addr;
                        state     <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (rom_q != TRANSP_IDX) begin
                            palette_out <= rom_q;
                            state       <= ST_DONE;
                        end else if (pending == 6'd0) begin
                            palette_out <= FALLBACK_IDX;
                            state       <= ST_DONE;
                        end else if (reads < MAX_R) begin
                            state <= ST_ISSUE;
                        end else begin
                            palette_out <= FALLBACK_IDX;
                            ovf_q       <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// tb/tb_sprite_layer_scheduler.sv - scoreboard bench for sprite_layer_scheduler
module tb_sprite_layer_scheduler;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pix_start = 1'b0;
    logic        blank = 1'b1;
    logic        B1D = 0, P1D = 0, B2D = 0, P2D = 0, terrain_on = 0, drawBG = 0;
    logic [17:0] B1A = 18'd100, P1A = 18'd200, B2A = 18'd300, P2A = 18'd400, addrBG = 18'd500;
    logic [17:0] rom_addr;
    logic [4:0]  rom_q = 5'd31;
    logic [4:0]  palette_out;
    logic        palette_valid, overflow, miss, busy;

    sprite_layer_scheduler dut (
        .Clk(Clk), .Reset(Reset), .pix_start(pix_start), .blank(blank),
        .B1D(B1D), .P1D(P1D), .B2D(B2D), .P2D(P2D), .terrain_on(terrain_on), .drawBG(drawBG),
        .B1A(B1A), .P1A(P1A), .B2A(B2A), .P2A(P2A), .addrBG(addrBG),
        .rom_addr(rom_addr), .rom_q(rom_q), .palette_out(palette_out),
        .palette_valid(palette_valid), .overflow(overflow), .miss(miss), .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0] pal;
        logic       ovf;
        int         at;
    } exp_t;

    exp_t        sb[$];
    int          rom[int];
    int          read_log[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [17:0] prev_addr = 18'd1704;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        rom_q <= rom.exists(int'(rom_addr)) ? 5'(rom[int'(rom_addr)]) : 5'd31;
    end

    always @(negedge Clk) begin
        if (rom_addr != prev_addr && rom_addr != 18'd1704) read_log.push_back(int'(rom_addr));
        prev_addr = rom_addr;
        if (palette_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(palette_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("palette_out", 32'(palette_out), 32'(e.pal));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("valid_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic drive_start(input logic [5:0] fl, input logic bl);
        {drawBG, terrain_on, P2D, B2D, P1D, B1D} = fl;
        blank = bl;
        pix_start = 1'b1;
        @(negedge Clk);
        pix_start = 1'b0;
        {drawBG, terrain_on, P2D, B2D, P1D, B1D} = 6'd0;
        blank = 1'b1;
    endtask

    task automatic pixel(input logic [5:0] fl, input logic bl, input logic [4:0] pal,
                         input logic ovf, input int lat);
        exp_t e;
        e.pal = pal;
        e.ovf = ovf;
        e.at  = cyc + lat;
        sb.push_back(e);
        drive_start(fl, bl);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_rom_addr", 32'(rom_addr), 32'd1704);
        check("rst_palette", 32'(palette_out), 32'd18);
        check("rst_valid", 32'(palette_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        rom[100] = 7;
        read_log.delete();
        pixel(6'b000011, 1'b1, 5'd7, 1'b0, 3);
        wait_drain();
        check("t1_nreads", 32'(read_log.size()), 32'd1);
        if (read_log.size() >= 1) check("t1_read0", 32'(read_log[0]), 32'd100);

        rom[100] = 31; rom[200] = 31; rom[500] = 9;
        read_log.delete();
        pixel(6'b100011, 1'b1, 5'd9, 1'b0, 7);
        wait_drain();
        check("t2_nreads", 32'(read_log.size()), 32'd3);
        if (read_log.size() == 3) begin
            check("t2_read0", 32'(read_log[0]), 32'd100);
            check("t2_read1", 32'(read_log[1]), 32'd200);
            check("t2_read2", 32'(read_log[2]), 32'd500);
        end

        rom[300] = 31; rom[400] = 5;
        read_log.delete();
        pixel(6'b111111, 1'b1, 5'd0, 1'b1, 7);
        wait_drain();
        check("t3_nreads", 32'(read_log.size()), 32'd3);
        foreach (read_log[i]) if (read_log[i] == 400) check("t3_no_p2_read", 32'(read_log[i]), 32'd0);

        read_log.delete();
        pixel(6'b111111, 1'b0, 5'd18, 1'b0, 1);
        wait_drain();
        check("t4_nreads", 32'(read_log.size()), 32'd0);

        pixel(6'b000000, 1'b1, 5'd0, 1'b0, 1);
        wait_drain();

        rom[1705] = 12;
        pixel(6'b010000, 1'b1, 5'd12, 1'b0, 3);
        check("t5_terrain_addr", 32'(rom_addr), 32'd1705);
        wait_drain();

        rom[100] = 7; rom[300] = 21;
        drive_start(6'b000001, 1'b1);
        @(negedge Clk);
        pixel(6'b000100, 1'b1, 5'd21, 1'b0, 3);
        check("t6_miss", 32'(miss), 32'd1);
        check("t6_old_palette", 32'(palette_out), 32'd12);
        @(negedge Clk);
        check("t6_miss_clear", 32'(miss), 32'd0);
        wait_drain();

        drive_start(6'b000001, 1'b1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("t7_rom_addr", 32'(rom_addr), 32'd1704);
        check("t7_palette", 32'(palette_out), 32'd18);
        check("t7_valid", 32'(palette_valid), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        check("t7_no_late_valid", 32'(palette_out), 32'd18);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
